// File: rtl/duty_ramp_sched_pkg.sv
// Shared types and constants for the duty ramp scheduler and its per-channel slew logic.
package duty_ramp_sched_pkg;

  localparam int unsigned DUTY_W = 11;
  localparam logic [DUTY_W-1:0] ZERO_DUTY_DEFAULT = 11'h400;

  typedef enum logic [2:0] {
    StIdle,
    StRamp,
    StHold,
    StDecel,
    StBrake
  } state_e;

endpackage

// File: rtl/duty_slew.sv
// One channel's next duty: moves cur toward goal by at most STEP, landing on goal exactly.
module duty_slew
  import duty_ramp_sched_pkg::*;
#(
  parameter logic [DUTY_W-1:0] STEP = 11'd16
) (
  input  logic [DUTY_W-1:0] cur,
  input  logic [DUTY_W-1:0] goal,
  output logic [DUTY_W-1:0] nxt
);

  logic signed [DUTY_W:0] diff;
  logic signed [DUTY_W:0] step_s;

  always_comb begin
    diff   = $signed({1'b0, goal}) - $signed({1'b0, cur});
    step_s = $signed({1'b0, STEP});
    // Clamping to goal on the final step keeps the result inside [0, 2047].
    if (diff > step_s) begin
      nxt = cur + STEP;
    end else if (diff < -step_s) begin
      nxt = cur - STEP;
    end else begin
      nxt = goal;
    end
  end

endmodule

// File: rtl/duty_ramp_sched.sv
// Two-channel PWM duty scheduler: slews duties toward targets once per PWM period, with brake.
module duty_ramp_sched
  import duty_ramp_sched_pkg::*;
#(
  parameter logic [DUTY_W-1:0] STEP      = 11'd16,
  parameter logic [DUTY_W-1:0] ZERO_DUTY = ZERO_DUTY_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              brake,
  input  logic              period_tick,
  input  logic [DUTY_W-1:0] lft_target,
  input  logic [DUTY_W-1:0] rght_target,
  output logic [DUTY_W-1:0] lft_duty,
  output logic [DUTY_W-1:0] rght_duty,
  output logic              at_target,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] lft_d, rght_d;
  logic [DUTY_W-1:0] lft_goal, rght_goal;
  logic [DUTY_W-1:0] lft_step, rght_step;

  // DECEL reuses the same slew path with the neutral duty as goal.
  assign lft_goal  = (state_q == StDecel) ? ZERO_DUTY : lft_target;
  assign rght_goal = (state_q == StDecel) ? ZERO_DUTY : rght_target;

  duty_slew #(.STEP(STEP)) u_lft_slew (
    .cur  (lft_duty),
    .goal (lft_goal),
    .nxt  (lft_step)
  );

  duty_slew #(.STEP(STEP)) u_rght_slew (
    .cur  (rght_duty),
    .goal (rght_goal),
    .nxt  (rght_step)
  );

  always_comb begin
    state_d = state_q;
    lft_d   = lft_duty;
    rght_d  = rght_duty;
    if (brake) begin
      state_d = StBrake;
      lft_d   = ZERO_DUTY;
      rght_d  = ZERO_DUTY;
    end else begin
      unique case (state_q)
        StIdle: begin
          lft_d  = ZERO_DUTY;
          rght_d = ZERO_DUTY;
          if (en) state_d = StRamp;
        end
        StRamp: begin
          if (!en) begin
            state_d = StDecel;
          end else if (period_tick) begin
            lft_d  = lft_step;
            rght_d = rght_step;
            if (lft_step == lft_target && rght_step == rght_target) state_d = StHold;
          end
        end
        StHold: begin
          if (!en) begin
            state_d = StDecel;
          end else if (lft_duty != lft_target || rght_duty != rght_target) begin
            state_d = StRamp;
          end
        end
        StDecel: begin
          if (en) begin
            state_d = StRamp;
          end else if (period_tick) begin
            lft_d  = lft_step;
            rght_d = rght_step;
            if (lft_step == ZERO_DUTY && rght_step == ZERO_DUTY) state_d = StIdle;
          end
        end
        StBrake: begin
          lft_d   = ZERO_DUTY;
          rght_d  = ZERO_DUTY;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      lft_duty  <= ZERO_DUTY;
      rght_duty <= ZERO_DUTY;
      at_target <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lft_duty  <= lft_d;
      rght_duty <= rght_d;
      at_target <= (state_d == StHold);
      busy      <= (state_d == StRamp) || (state_d == StDecel);
    end
  end

endmodule

// File: tb/tb_duty_ramp_sched.sv
// Directed bench for duty_ramp_sched with hand-computed expected duties and flags.
module tb_duty_ramp_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        brake;
  logic        period_tick;
  logic [10:0] lft_target;
  logic [10:0] rght_target;
  logic [10:0] lft_duty;
  logic [10:0] rght_duty;
  logic        at_target;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  duty_ramp_sched dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .brake       (brake),
    .period_tick (period_tick),
    .lft_target  (lft_target),
    .rght_target (rght_target),
    .lft_duty    (lft_duty),
    .rght_duty   (rght_duty),
    .at_target   (at_target),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      period_tick = 1'b1;
      step();
      period_tick = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; brake = 1'b0; period_tick = 1'b0;
    lft_target = 11'h400; rght_target = 11'h400;
    step(); step();
    rst = 1'b0;
    step();
    check("reset_lft", {1'b0, lft_duty}, 12'h400);
    check("reset_rght", {1'b0, rght_duty}, 12'h400);
    check("reset_at_target", {11'b0, at_target}, 12'h0);
    check("reset_busy", {11'b0, busy}, 12'h0);

    // Ramp left to 0x480 in 8 ticks of 16.
    lft_target = 11'h480; rght_target = 11'h400; en = 1'b1;
    step();
    check("ramp_enter_busy", {11'b0, busy}, 12'h1);
    check("ramp_enter_lft", {1'b0, lft_duty}, 12'h400);
    for (int i = 1; i <= 8; i++) begin
      tick_n(1);
      check($sformatf("ramp_lft_%0d", i), {1'b0, lft_duty}, 12'(12'h400 + 16 * i));
    end
    check("ramp_rght_still", {1'b0, rght_duty}, 12'h400);
    check("hold_at_target", {11'b0, at_target}, 12'h1);
    check("hold_busy", {11'b0, busy}, 12'h0);
    step(); step();
    check("no_tick_no_change", {1'b0, lft_duty}, 12'h480);

    // Drop en: decelerate back to neutral, then IDLE.
    en = 1'b0;
    step();
    check("decel_busy", {11'b0, busy}, 12'h1);
    check("decel_at_target", {11'b0, at_target}, 12'h0);
    for (int i = 1; i <= 8; i++) begin
      tick_n(1);
      check($sformatf("decel_lft_%0d", i), {1'b0, lft_duty}, 12'(12'h480 - 16 * i));
    end
    check("idle_busy", {11'b0, busy}, 12'h0);
    step();
    check("idle_stays", {11'b0, busy}, 12'h0);

    // Small step lands exactly on target.
    lft_target = 11'h405; en = 1'b1;
    step();
    tick_n(1);
    check("small_step_lft", {1'b0, lft_duty}, 12'h405);
    check("small_step_hold", {11'b0, at_target}, 12'h1);

    // Upper boundary: 0x400 -> 0x7F8 (64 ticks), then 0x7FF with a 7-count step.
    rght_target = 11'h7F8;
    step();
    check("hold_to_ramp_busy", {11'b0, busy}, 12'h1);
    tick_n(64);
    check("rght_7f8", {1'b0, rght_duty}, 12'h7F8);
    rght_target = 11'h7FF;
    step();
    tick_n(1);
    check("rght_7ff_no_wrap", {1'b0, rght_duty}, 12'h7FF);
    check("rght_7ff_hold", {11'b0, at_target}, 12'h1);

    // Lower boundary: 0x7FF -> 0x008 (128 ticks), then 0x000 with an 8-count step.
    rght_target = 11'h008;
    step();
    tick_n(128);
    check("rght_008", {1'b0, rght_duty}, 12'h008);
    rght_target = 11'h000;
    step();
    tick_n(1);
    check("rght_000_no_wrap", {1'b0, rght_duty}, 12'h000);
    check("lft_kept_405", {1'b0, lft_duty}, 12'h405);

    // Decelerate to IDLE: right needs 64 ticks to climb back to 0x400.
    en = 1'b0;
    step();
    tick_n(64);
    check("decel2_rght", {1'b0, rght_duty}, 12'h400);
    check("decel2_lft", {1'b0, lft_duty}, 12'h400);
    check("decel2_idle_busy", {11'b0, busy}, 12'h0);

    // Brake mid-ramp at 0x440 without a tick.
    lft_target = 11'h480; rght_target = 11'h400; en = 1'b1;
    step();
    tick_n(4);
    check("pre_brake_lft", {1'b0, lft_duty}, 12'h440);
    brake = 1'b1;
    step();
    check("brake_lft", {1'b0, lft_duty}, 12'h400);
    check("brake_busy", {11'b0, busy}, 12'h0);
    tick_n(1);
    check("brake_held_lft", {1'b0, lft_duty}, 12'h400);
    check("brake_held_busy", {11'b0, busy}, 12'h0);
    brake = 1'b0;
    step();
    check("brake_release_idle", {11'b0, busy}, 12'h0);
    step();
    check("idle_to_ramp_busy", {11'b0, busy}, 12'h1);

    // Reset mid-ramp at 0x460 abandons the ramp.
    tick_n(6);
    check("pre_rst_lft", {1'b0, lft_duty}, 12'h460);
    rst = 1'b1;
    step();
    check("rst_lft", {1'b0, lft_duty}, 12'h400);
    check("rst_rght", {1'b0, rght_duty}, 12'h400);
    check("rst_at_target", {11'b0, at_target}, 12'h0);
    check("rst_busy", {11'b0, busy}, 12'h0);
    rst = 1'b0; en = 1'b0;
    step();
    check("post_rst_idle", {11'b0, busy}, 12'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/duty_ramp_sched.md
DUTY_RAMP_SCHED -- requirements
Module: duty_ramp_sched

Interface
REQ-001 SHALL have parameter STEP, default 11'd16, meaning the maximum duty change per channel per PWM period.
REQ-002 SHALL have parameter ZERO_DUTY, default 11'h400, meaning the stop/neutral duty of the 11-bit PWM drive.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning reset; it is synchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit, meaning run request; high means ramp to targets, low means ramp to ZERO_DUTY.
REQ-006 SHALL have port brake, input, 1 bit, meaning emergency stop, highest priority.
REQ-007 SHALL have port period_tick, input, 1 bit, meaning a one-cycle pulse at each PWM counter wrap (count 2047 -> 0).
REQ-008 SHALL have port lft_target, input, 11 bits, meaning the left channel requested duty.
REQ-009 SHALL have port rght_target, input, 11 bits, meaning the right channel requested duty.
REQ-010 SHALL have port lft_duty, output, 11 bits, meaning the registered duty driven to the left 11-bit PWM generator.
REQ-011 SHALL have port rght_duty, output, 11 bits, meaning the registered duty driven to the right 11-bit PWM generator.
REQ-012 SHALL have port at_target, output, 1 bit, meaning the state is HOLD.
REQ-013 SHALL have port busy, output, 1 bit, meaning the state is RAMP or DECEL.

Function
REQ-014 SHALL implement the states IDLE, RAMP, HOLD, DECEL and BRAKE.
REQ-015 IDLE: both duties SHALL be held at ZERO_DUTY; en=1 SHALL move the state to RAMP on the next cycle.
REQ-016 RAMP: on each cycle with period_tick=1, each duty SHALL move toward its target by min(STEP, |target-duty|).
REQ-017 RAMP -> HOLD SHALL occur when both duties equal their targets after an update.
REQ-018 Step arithmetic SHALL use a 12-bit signed difference and SHALL never overshoot the target or wrap past 0/2047.
REQ-019 Duties SHALL NOT change on cycles where period_tick=0, in any state other than BRAKE.
REQ-020 Duty registers SHALL update one clk after the cycle that samples period_tick=1.
REQ-021 HOLD: if either target differs from its duty, the state SHALL return to RAMP; the step count SHALL NOT be reset.
REQ-022 A target change during RAMP SHALL be followed from the next tick, with no restart.
REQ-023 en=0 in RAMP or HOLD SHALL move the state to DECEL on the next cycle.
REQ-024 DECEL SHALL ramp both duties toward ZERO_DUTY with the same step rule, then go to IDLE when both duties equal ZERO_DUTY.
REQ-025 en=1 during DECEL SHALL return the state to RAMP on the next cycle.
REQ-026 brake=1 in any state SHALL move the state to BRAKE and force both duties to ZERO_DUTY on the next clk, regardless of period_tick.
REQ-027 BRAKE SHALL be held while brake=1; brake=0 SHALL move the state to IDLE, even if en=1.
REQ-028 Priority SHALL be rst > brake > en transitions > period_tick update.

Reset
REQ-029 rst=1 SHALL set state to IDLE, lft_duty and rght_duty to ZERO_DUTY, at_target=0 and busy=0 on the next clk.
REQ-030 rst asserted mid-ramp SHALL abandon the ramp immediately; no stepped deceleration.

Structure
REQ-031 A shared package SHALL hold the state enum type, DUTY_W=11 and the ZERO_DUTY default constant.
REQ-032 One sub-module, duty_slew, SHALL implement the per-channel step/clamp logic and SHALL be instantiated twice.
REQ-033 The FSM SHALL reside in duty_ramp_sched.
REQ-034 All outputs SHALL be registered.

Verification
REQ-035 Bench SHALL cover: en=1, lft_target=0x480, rght_target=0x400, with ticks -> lft_duty 0x410, 0x420, ... reaching 0x480 after 8 ticks; at_target=1.
REQ-036 Bench SHALL cover: lft_target=0x405 from 0x400 -> one tick gives 0x405 exactly (no overshoot), then HOLD.
REQ-037 Bench SHALL cover: at HOLD 0x480, drop en -> DECEL, 8 ticks back to 0x400, then IDLE with busy=0.
REQ-038 Bench SHALL cover: brake pulsed mid-RAMP at duty 0x440 with period_tick=0 -> next clk duty=0x400, state BRAKE; release -> IDLE.
REQ-039 Bench SHALL cover: rght_target=0x7FF, STEP=16 from 0x7F8 -> 0x7FF, no wrap; rght_target=0x000 from 0x008 -> 0x000.
REQ-040 Bench SHALL cover: rst asserted at duty 0x460 during RAMP -> next clk both duties 0x400, IDLE, at_target=0.
